// File: rtl/qclk_pkg.sv
// Shared qclk definitions: counter width, timestamp type and command-queue controller states.
package qclk_pkg;

   localparam int QCLK_WIDTH = 32;

   typedef logic [QCLK_WIDTH-1:0] qtime_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      FIRE
   } cmdq_state_t;

endpackage

// File: rtl/cmdq_fifo_mem.sv
// Circular command buffer: wrap-bit read/write pointers, full/empty/occupancy and a {time, data} storage array.
module cmdq_fifo_mem #(
   parameter int TIME_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [TIME_WIDTH-1:0]    wr_time,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   output logic [TIME_WIDTH-1:0]    head_time,
   output logic [DATA_WIDTH-1:0]    head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic [TIME_WIDTH+DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr + PTR_ONE;
      end
   end

   // Storage carries no reset; only the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= {wr_time, wr_data};
   end

   assign {head_time, head_data} = mem[rptr[AW-1:0]];

   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty = (wptr == rptr);
   assign count = wptr - rptr;

endmodule

// File: rtl/timed_cmd_queue.sv
// Holds timestamped commands until qclk reaches their time, then fires each as a one-cycle pulse (late-aware).
// Build option: TIMED_CMD_QUEUE_LATE_DROP_EN drops late heads with a one-cycle out_late notification instead of emitting them.
module timed_cmd_queue
   import qclk_pkg::*;
#(
   parameter int TIME_WIDTH = QCLK_WIDTH,
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [TIME_WIDTH-1:0]    qclk_val,
   input  logic                     run,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [TIME_WIDTH-1:0]    in_time,
   input  logic [DATA_WIDTH-1:0]    in_data,
   output logic                     out_valid,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic                     out_late,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_ONE = 1;

   logic [TIME_WIDTH-1:0] head_time;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  full;
   logic                  empty;
   logic [TIME_WIDTH-1:0] diff;
   logic                  due_time;
   logic                  late_p0;
   logic                  fire;
   logic                  push;
   logic                  pop;
   cmdq_state_t           state_q;
   cmdq_state_t           state;
   cmdq_state_t           state_nx;

   assign in_ready = !full;
   assign push     = in_valid && !full && !flush;
   assign pop      = fire && !flush;

   cmdq_fifo_mem #(
      .TIME_WIDTH (TIME_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .pop       (pop),
      .wr_time   (in_time),
      .wr_data   (in_data),
      .head_time (head_time),
      .head_data (head_data),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   // Modular difference: a set MSB means the timestamp is behind qclk (or more than half a wrap ahead).
   assign diff     = head_time - qclk_val;
   assign due_time = (diff == '0) || diff[TIME_WIDTH-1];
   assign late_p0  = (diff != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_nx;
   end

   // state_q only records occupancy (IDLE/WAIT); FIRE is the in-cycle view when the head pops.
   always_comb begin
      fire     = 1'b0;
      state    = state_q;
      state_nx = state_q;
      if ((state_q != IDLE) && !empty && run && due_time) begin
         fire  = 1'b1;
         state = FIRE;
      end
      unique case (state)
         IDLE:    state_nx = push ? WAIT : IDLE;
         WAIT:    state_nx = WAIT;
         FIRE:    state_nx = ((count > CNT_ONE) || push) ? WAIT : IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   // Output stage: decision from cycle N becomes visible in cycle N+1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_late  <= 1'b0;
         out_data  <= '0;
      end else if (pop) begin
`ifdef TIMED_CMD_QUEUE_LATE_DROP_EN
         if (late_p0) begin
            out_valid <= 1'b0;
            out_late  <= 1'b1;
         end else begin
            out_valid <= 1'b1;
            out_late  <= 1'b0;
            out_data  <= head_data;
         end
`else
         out_valid <= 1'b1;
         out_late  <= late_p0;
         out_data  <= head_data;
`endif
      end else begin
         out_valid <= 1'b0;
         out_late  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_timed_cmd_queue.sv
// Self-checking bench for timed_cmd_queue: vector table, directed corner sequences and a random run against a queue model.
module tb_timed_cmd_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] qclk_val;
   logic        run;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_time;
   logic [63:0] in_data;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_late;
   logic [3:0]  count;

`ifdef TIMED_CMD_QUEUE_LATE_DROP_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   timed_cmd_queue dut (
      .clk       (clk),
      .rst       (rst),
      .qclk_val  (qclk_val),
      .run       (run),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_time   (in_time),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_late  (out_late),
      .count     (count)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   // Reference model: plain queue of pending commands plus expected output registers.
   bit [31:0] mq_t[$];
   bit [63:0] mq_d[$];
   bit        m_valid;
   bit        m_late;
   bit [63:0] m_data;

   typedef struct {
      bit        f;
      bit        iv;
      bit        r;
      bit [31:0] q;
      bit [31:0] t;
      bit [63:0] d;
      bit        ev;
      bit        el;
      bit [63:0] ed;
      int        ec;
   } vec_t;

   vec_t tbl[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mq_t.delete();
      mq_d.delete();
      m_valid = 1'b0;
      m_late  = 1'b0;
      m_data  = '0;
   endtask

   // Applies the queue rules for the current cycle's inputs, as seen at the coming edge.
   task automatic model_step();
      bit [31:0] d;
      bit        due;
      bit        rdy;
      rdy = (mq_t.size() < 8);
      due = 1'b0;
      d   = '0;
      if (run && mq_t.size() > 0) begin
         d   = mq_t[0] - qclk_val;
         due = (d == 0) || d[31];
      end
      m_valid = 1'b0;
      m_late  = 1'b0;
      if (flush) begin
         mq_t.delete();
         mq_d.delete();
      end else begin
         if (due) begin
            if (DROP && d != 0) begin
               m_late = 1'b1;
            end else begin
               m_valid = 1'b1;
               m_late  = (d != 0);
               m_data  = mq_d[0];
            end
            void'(mq_t.pop_front());
            void'(mq_d.pop_front());
         end
         if (in_valid && rdy) begin
            mq_t.push_back(in_time);
            mq_d.push_back(in_data);
         end
      end
   endtask

   task automatic step(input bit f, input bit iv, input bit r, input bit [31:0] q,
                       input bit [31:0] t, input bit [63:0] d);
      @(negedge clk);
      flush    = f;
      in_valid = iv;
      run      = r;
      qclk_val = q;
      in_time  = t;
      in_data  = d;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".valid"}, out_valid, m_valid);
      check({tag, ".late"},  out_late,  m_late);
      check({tag, ".data"},  out_data,  m_data);
      check({tag, ".count"}, count,     mq_t.size());
      check({tag, ".ready"}, in_ready,  mq_t.size() < 8);
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit [31:0] q;
      bit [31:0] t;

      //        f  iv r  qclk  time data   ev el ed             ec
      tbl[0]  = '{0, 1, 1, 96,  100, 'hA5, 0, 0, 0,             1};
      tbl[1]  = '{0, 0, 1, 97,  0,   0,    0, 0, 0,             1};
      tbl[2]  = '{0, 0, 1, 98,  0,   0,    0, 0, 0,             1};
      tbl[3]  = '{0, 0, 1, 99,  0,   0,    0, 0, 0,             1};
      tbl[4]  = '{0, 0, 1, 100, 0,   0,    1, 0, 'hA5,          0};
      tbl[5]  = '{0, 0, 1, 101, 0,   0,    0, 0, 'hA5,          0};
      tbl[6]  = '{0, 1, 1, 40,  50,  1,    0, 0, 'hA5,          1};
      tbl[7]  = '{0, 1, 1, 41,  50,  2,    0, 0, 'hA5,          2};
      tbl[8]  = '{0, 0, 1, 50,  0,   0,    1, 0, 1,             1};
      tbl[9]  = '{0, 0, 1, 51,  0,   0,    !DROP, 1, DROP ? 1 : 2, 0};
      tbl[10] = '{0, 0, 1, 52,  0,   0,    0, 0, DROP ? 1 : 2,  0};

      rst = 1'b1; run = 1'b0; flush = 1'b0; in_valid = 1'b0;
      qclk_val = '0; in_time = '0; in_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset.valid", out_valid, 0);
      check("reset.late",  out_late,  0);
      check("reset.data",  out_data,  0);
      check("reset.count", count,     0);
      check("reset.ready", in_ready,  1);
      @(negedge clk);
      rst = 1'b0;

      // Exact fire and same-timestamp pair
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].f, tbl[i].iv, tbl[i].r, tbl[i].q, tbl[i].t, tbl[i].d);
         check($sformatf("tbl%0d.valid", i), out_valid, tbl[i].ev);
         check($sformatf("tbl%0d.late",  i), out_late,  tbl[i].el);
         check($sformatf("tbl%0d.data",  i), out_data,  tbl[i].ed);
         check($sformatf("tbl%0d.count", i), count,     tbl[i].ec);
      end

      // Late command: fires on the cycle after the push
      step(0, 1, 1, 200, 150, 64'h77);
      check("late.push_valid", out_valid, 0);
      check("late.push_count", count, 1);
      step(0, 0, 1, 201, 0, 0);
      check("late.valid", out_valid, !DROP);
      check("late.late",  out_late,  1);
      check_model("late");

      // Wrap-around target time
      step(0, 1, 1, 32'hFFFF_FFFE, 32'h1, 64'h5A);
      step(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
      check("wrap.ffff.valid", out_valid, 0);
      step(0, 0, 1, 32'h0, 0, 0);
      check("wrap.zero.valid", out_valid, 0);
      step(0, 0, 1, 32'h1, 0, 0);
      check("wrap.valid", out_valid, 1);
      check("wrap.late",  out_late,  0);
      check("wrap.data",  out_data,  64'h5A);
      check("wrap.count", count,     0);

      // Fill with run=0, overflow attempt, then drain all-late entries in order
      for (int i = 0; i < 8; i++) step(0, 1, 0, 1000, 10 + i, 64'h100 + i);
      check("full.count", count, 8);
      check("full.ready", in_ready, 0);
      step(0, 1, 0, 1000, 5, 64'hDEAD);
      check("full.ignored_count", count, 8);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, 2000, 0, 0);
         check($sformatf("drain%0d.valid", i), out_valid, !DROP);
         check($sformatf("drain%0d.late",  i), out_late,  1);
         check($sformatf("drain%0d.data",  i), out_data,  DROP ? 64'h5A : 64'h100 + i);
         check($sformatf("drain%0d.count", i), count,     7 - i);
      end
      step(0, 0, 1, 2001, 0, 0);
      check("drain.after_valid", out_valid, 0);

      // Flush in the due cycle, with a simultaneous push that must be discarded
      step(0, 1, 1, 290, 300, 64'hF1);
      step(0, 0, 1, 295, 0, 0);
      step(1, 1, 1, 300, 301, 64'hF2);
      check("flush.valid", out_valid, 0);
      check("flush.count", count, 0);
      step(0, 0, 1, 301, 0, 0);
      check("flush.after_valid", out_valid, 0);
      check("flush.after_count", count, 0);
      check_model("flush");

      // Asynchronous reset while a pulse is being presented
      step(0, 1, 1, 400, 410, 64'hB1);
      step(0, 1, 1, 401, 405, 64'hB2);
      step(0, 0, 1, 410, 0, 0);
      check("arst.pre_valid", out_valid, 1);
      check("arst.pre_count", count, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst.valid", out_valid, 0);
      check("arst.late",  out_late,  0);
      check("arst.data",  out_data,  0);
      check("arst.count", count,     0);
      check("arst.ready", in_ready,  1);
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Randomized traffic against the model
      q = 32'h7FFF_FFF0;
      for (int i = 0; i < 600; i++) begin
         q = q + (($urandom % 8 == 0) ? $urandom_range(0, 20) : 1);
         if ($urandom % 16 == 0) t = q + 32'h8000_0005;
         else                    t = q + $urandom_range(0, 14) - 4;
         step($urandom % 40 == 0, $urandom % 2, $urandom % 10 != 0, q, t, {$urandom, $urandom});
         check_model($sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
